// File: rtl/echo_pkg.sv
// Shared types, constants and helpers for the echo controller.
package echo_pkg;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StWait,
    StMix,
    StWrite
  } echo_state_e;

  localparam int unsigned GainWidth = 8;
  // Unsigned Q1.7 unity gain.
  localparam logic [GainWidth-1:0] QOne = 8'd128;
  localparam int unsigned GainShift = $clog2(QOne);

  // Most positive (neg=0) or most negative (neg=1) value of a signed width-bit word.
  function automatic logic signed [63:0] sat_limit(int unsigned width, logic neg);
    logic signed [63:0] one;
    one = 64'sd1;
    return neg ? -(one <<< (width - 1)) : (one <<< (width - 1)) - 64'sd1;
  endfunction

endpackage

// File: rtl/echo_ctrl_if.sv
// Sample stream, control inputs and delay-RAM port of the echo controller.
interface echo_ctrl_if
  import echo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 31,
  parameter int unsigned ADDR_WIDTH = 14
) ();

  logic signed [DATA_WIDTH-1:0] SAMPLE_IN;
  logic                         SAMPLE_VALID;
  logic                         READY;
  logic                         ENABLE;
  logic        [ADDR_WIDTH-1:0] DELAY;
  logic        [GainWidth-1:0]  FB_GAIN;
  logic        [GainWidth-1:0]  MIX_GAIN;
  logic                         WE;
  logic        [ADDR_WIDTH-1:0] ADDR1;
  logic        [ADDR_WIDTH-1:0] ADDR2;
  logic signed [DATA_WIDTH-1:0] DI;
  logic signed [DATA_WIDTH-1:0] DO2;
  logic signed [DATA_WIDTH-1:0] OUT_DATA;
  logic                         OUT_VALID;
  logic                         OVERRUN;

  modport slave (
    input  SAMPLE_IN, SAMPLE_VALID, ENABLE, DELAY, FB_GAIN, MIX_GAIN, DO2,
    output READY, WE, ADDR1, ADDR2, DI, OUT_DATA, OUT_VALID, OVERRUN
  );

  modport master (
    output SAMPLE_IN, SAMPLE_VALID, ENABLE, DELAY, FB_GAIN, MIX_GAIN, DO2,
    input  READY, WE, ADDR1, ADDR2, DI, OUT_DATA, OUT_VALID, OVERRUN
  );

endinterface

// File: rtl/echo_sat_scale.sv
// Signed scale-and-add with saturation: res = sat(dry + (dly * gain) >>> 7).
module echo_sat_scale
  import echo_pkg::*;
#(
  parameter int unsigned DataWidth = 31
) (
  input  logic signed [DataWidth-1:0] dry_i,
  input  logic signed [DataWidth-1:0] dly_i,
  input  logic        [GainWidth-1:0] gain_i,
  output logic signed [DataWidth-1:0] res_o
);

  localparam int unsigned ProdWidth = DataWidth + GainWidth + 1;
  localparam int unsigned ExtWidth  = ProdWidth - DataWidth;

  logic signed [ProdWidth-1:0] prod;
  logic signed [ProdWidth-1:0] scaled;
  logic signed [ProdWidth-1:0] sum;
  logic signed [63:0]          sum_ext;
  logic signed [63:0]          lim_hi;
  logic signed [63:0]          lim_lo;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    prod    = $signed({{ExtWidth{dly_i[DataWidth-1]}}, dly_i}) *
              $signed({{(ProdWidth - GainWidth){1'b0}}, gain_i});
    scaled  = prod >>> GainShift;
    sum     = scaled + $signed({{ExtWidth{dry_i[DataWidth-1]}}, dry_i});
    sum_ext = {{(64 - ProdWidth){sum[ProdWidth-1]}}, sum};
    lim_hi  = sat_limit(DataWidth, 1'b0);
    lim_lo  = sat_limit(DataWidth, 1'b1);
    if (sum_ext > lim_hi) begin
      res_o = DataWidth'(lim_hi);
    end else if (sum_ext < lim_lo) begin
      res_o = DataWidth'(lim_lo);
    end else begin
      res_o = DataWidth'(sum);
    end
  end

endmodule

// File: rtl/echo_ctrl.sv
// Echo/delay controller: clears the external delay RAM after reset, then for each accepted
// sample reads the delayed word, mixes wet/dry output and writes the feedback word back.
module echo_ctrl
  import echo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 31,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned SIZE       = 20000,
  parameter int unsigned RD_LAT     = 2
) (
  input logic        CLK,
  input logic        RST_N,
  echo_ctrl_if.slave bus
);

  localparam int unsigned LatWidth = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [ADDR_WIDTH:0]   SizeW  = (ADDR_WIDTH + 1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] SizeM1 = ADDR_WIDTH'(SIZE - 1);

  echo_state_e                  state_q, state_d;
  logic        [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic        [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic        [LatWidth-1:0]   lat_cnt_q, lat_cnt_d;
  logic signed [DATA_WIDTH-1:0] dry_q, dry_d;
  logic signed [DATA_WIDTH-1:0] dly_q, dly_d;
  logic                         en_q, en_d;
  logic        [GainWidth-1:0]  fb_gain_q, fb_gain_d;
  logic        [GainWidth-1:0]  mix_gain_q, mix_gain_d;
  logic                         we_q, we_d;
  logic        [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic        [ADDR_WIDTH-1:0] addr2_q, addr2_d;
  logic signed [DATA_WIDTH-1:0] di_q, di_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         ready_q, ready_d;
  logic                         overrun_q, overrun_d;

  logic        [ADDR_WIDTH-1:0] d_clamp;
  logic        [ADDR_WIDTH-1:0] rd_addr;
  logic signed [DATA_WIDTH-1:0] mix_res;
  logic signed [DATA_WIDTH-1:0] fb_res;

  echo_sat_scale #(.DataWidth(DATA_WIDTH)) u_mix (
    .dry_i  (dry_q),
    .dly_i  (dly_q),
    .gain_i (mix_gain_q),
    .res_o  (mix_res)
  );

  echo_sat_scale #(.DataWidth(DATA_WIDTH)) u_fb (
    .dry_i  (dry_q),
    .dly_i  (dly_q),
    .gain_i (fb_gain_q),
    .res_o  (fb_res)
  );

  // Clamp the delay to 1..SIZE-1 so the read never hits the word being written.
  always_comb begin
    if (bus.DELAY == '0) begin
      d_clamp = ADDR_WIDTH'(1);
    end else if ({1'b0, bus.DELAY} >= SizeW) begin
      d_clamp = SizeM1;
    end else begin
      d_clamp = bus.DELAY;
    end
    if (wr_ptr_q >= d_clamp) begin
      rd_addr = wr_ptr_q - d_clamp;
    end else begin
      rd_addr = ADDR_WIDTH'({1'b0, wr_ptr_q} + SizeW - {1'b0, d_clamp});
    end
  end

  // Next-state and registered-output logic of the sample FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    clr_cnt_d   = clr_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    dry_d       = dry_q;
    dly_d       = dly_q;
    en_d        = en_q;
    fb_gain_d   = fb_gain_q;
    mix_gain_d  = mix_gain_q;
    we_d        = we_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    di_d        = di_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    ready_d     = ready_q;
    overrun_d   = overrun_q | (bus.SAMPLE_VALID & ~ready_q);

    case (state_q)
      StClear: begin
        if (clr_cnt_q == SizeW) begin
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          we_d      = 1'b1;
          di_d      = '0;
          addr1_d   = ADDR_WIDTH'(clr_cnt_q);
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        we_d = 1'b0;
        if (bus.SAMPLE_VALID && ready_q) begin
          dry_d      = bus.SAMPLE_IN;
          en_d       = bus.ENABLE;
          fb_gain_d  = bus.FB_GAIN;
          mix_gain_d = bus.MIX_GAIN;
          addr2_d    = rd_addr;
          lat_cnt_d  = '0;
          ready_d    = 1'b0;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (lat_cnt_q == LatWidth'(RD_LAT)) begin
          dly_d   = bus.DO2;
          state_d = StMix;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StMix: begin
        we_d        = 1'b1;
        addr1_d     = wr_ptr_q;
        out_valid_d = 1'b1;
        out_data_d  = en_q ? mix_res : dry_q;
        di_d        = en_q ? fb_res : dry_q;
        state_d     = StWrite;
      end
      StWrite: begin
        we_d     = 1'b0;
        wr_ptr_d = (wr_ptr_q == SizeM1) ? '0 : wr_ptr_q + 1'b1;
        ready_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StClear;
      wr_ptr_q    <= '0;
      clr_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      dry_q       <= '0;
      dly_q       <= '0;
      en_q        <= 1'b0;
      fb_gain_q   <= '0;
      mix_gain_q  <= '0;
      we_q        <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      di_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      clr_cnt_q   <= clr_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      dry_q       <= dry_d;
      dly_q       <= dly_d;
      en_q        <= en_d;
      fb_gain_q   <= fb_gain_d;
      mix_gain_q  <= mix_gain_d;
      we_q        <= we_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      di_q        <= di_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.READY     = ready_q;
  assign bus.WE        = we_q;
  assign bus.ADDR1     = addr1_q;
  assign bus.ADDR2     = addr2_q;
  assign bus.DI        = di_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_echo_ctrl.sv
// Bench for echo_ctrl: behavioural delay-RAM plus a sample-level reference model of the echo.
// A small SIZE keeps the clear sweep and the pointer wrap short.
module tb_echo_ctrl;

  localparam int unsigned DW     = 31;
  localparam int unsigned AW     = 14;
  localparam int unsigned SIZE   = 48;
  localparam int unsigned RD_LAT = 2;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  echo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  echo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SIZE       (SIZE),
    .RD_LAT     (RD_LAT)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // External delay RAM: write port 1, read port 2 with RD_LAT cycles of latency.
  logic signed [DW-1:0] ram     [SIZE];
  logic signed [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge CLK) begin
    if (bus.WE && (bus.ADDR1 < AW'(SIZE))) ram[bus.ADDR1] <= bus.DI;
    rd_pipe[0] <= (bus.ADDR2 < AW'(SIZE)) ? ram[bus.ADDR2] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.DO2 = rd_pipe[RD_LAT-1];

  // Reference model state: what the RAM should hold, next write slot, sticky overrun.
  longint mdl_mem [SIZE];
  int     mdl_ptr;
  bit     mdl_ovr;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic longint rand_sample();
    logic signed [DW-1:0] s;
    s = DW'($urandom);
    return longint'(s);
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < SIZE; i++) mdl_mem[i] = 0;
    mdl_ptr = 0;
    mdl_ovr = 0;
  endtask

  task automatic check_reset_state();
    check_val("rst_we", bus.WE, 0);
    check_val("rst_ready", bus.READY, 0);
    check_val("rst_out_valid", bus.OUT_VALID, 0);
    check_val("rst_overrun", bus.OVERRUN, 0);
    check_val("rst_addr1", bus.ADDR1, 0);
    check_val("rst_addr2", bus.ADDR2, 0);
    check_val("rst_di", bus.DI, 0);
    check_val("rst_out_data", bus.OUT_DATA, 0);
  endtask

  // Called at a negedge with RST_N low; releases reset and follows the whole clear sweep.
  task automatic do_clear();
    RST_N = 1'b1;
    for (int k = 1; k <= SIZE; k++) begin
      @(negedge CLK);
      check_val("clr_we", bus.WE, 1);
      check_val("clr_addr1", bus.ADDR1, k - 1);
      check_val("clr_di", bus.DI, 0);
      check_val("clr_ready", bus.READY, 0);
    end
    @(negedge CLK);
    check_val("clr_done_we", bus.WE, 0);
    check_val("clr_done_ready", bus.READY, 1);
    mdl_reset();
  endtask

  task automatic restart();
    RST_N = 1'b0;
    @(negedge CLK);
    check_reset_state();
    do_clear();
  endtask

  // mode 0: plain sample; 1: extra strobe during WAIT (must be dropped); 2: reset during MIX.
  task automatic send(input longint dry, input bit en, input int delay, input int fb,
                      input int mix, input int mode);
    int     guard;
    int     d;
    int     raddr;
    longint dly, outv, wrv;
    guard = 0;
    while (bus.READY !== 1'b1 && guard < 4 * SIZE) begin
      @(negedge CLK);
      guard++;
    end
    if (bus.READY !== 1'b1) begin
      check_val("ready_timeout", bus.READY, 1);
      return;
    end
    d     = (delay == 0) ? 1 : ((delay > SIZE - 1) ? SIZE - 1 : delay);
    raddr = (mdl_ptr - d + SIZE) % SIZE;
    dly   = mdl_mem[raddr];
    if (en) begin
      outv = sat(dry + ((dly * mix) >>> 7));
      wrv  = sat(dry + ((dly * fb) >>> 7));
    end else begin
      outv = dry;
      wrv  = dry;
    end
    bus.SAMPLE_IN    = DW'(dry);
    bus.ENABLE       = en;
    bus.DELAY        = AW'(delay);
    bus.FB_GAIN      = 8'(fb);
    bus.MIX_GAIN     = 8'(mix);
    bus.SAMPLE_VALID = 1'b1;
    for (int k = 1; k <= RD_LAT + 4; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        bus.SAMPLE_VALID = 1'b0;
        check_val("addr2", bus.ADDR2, raddr);
        check_val("busy_ready", bus.READY, 0);
        if (mode == 1) begin
          bus.SAMPLE_VALID = 1'b1;
          bus.SAMPLE_IN    = DW'(dry + 12345);
          mdl_ovr          = 1;
        end
      end
      if (k == 2) bus.SAMPLE_VALID = 1'b0;
      if (k == RD_LAT + 2) begin
        check_val("early_we", bus.WE, 0);
        check_val("early_out_valid", bus.OUT_VALID, 0);
        if (mode == 2) RST_N = 1'b0;
      end
      if (k == RD_LAT + 3) begin
        if (mode == 2) begin
          check_reset_state();
          return;
        end
        check_val("out_valid", bus.OUT_VALID, 1);
        check_val("we", bus.WE, 1);
        check_val("addr1", bus.ADDR1, mdl_ptr);
        check_val("di", bus.DI, wrv);
        check_val("out_data", bus.OUT_DATA, outv);
      end
      if (k == RD_LAT + 4) begin
        check_val("ready_back", bus.READY, 1);
        check_val("strobe_end", bus.OUT_VALID, 0);
        check_val("we_end", bus.WE, 0);
        check_val("out_hold", bus.OUT_DATA, outv);
        check_val("overrun", bus.OVERRUN, mdl_ovr);
      end
    end
    mdl_mem[mdl_ptr] = wrv;
    mdl_ptr          = (mdl_ptr + 1) % SIZE;
  endtask

  initial begin
    longint max_s, min_s;
    int     dly;
    max_s = (longint'(1) <<< (DW - 1)) - 1;
    min_s = -max_s - 1;
    bus.SAMPLE_IN    = '0;
    bus.SAMPLE_VALID = 1'b0;
    bus.ENABLE       = 1'b0;
    bus.DELAY        = '0;
    bus.FB_GAIN      = '0;
    bus.MIX_GAIN     = '0;
    mdl_reset();

    repeat (3) @(negedge CLK);
    check_reset_state();
    do_clear();

    // Bypass: dry straight through, first write lands at address 0.
    send(1000, 1'b0, 5, 0, 0, 0);

    // Impulse through a 3-sample echo at half mix, no feedback.
    restart();
    send(1024, 1'b1, 3, 0, 64, 0);
    repeat (5) send(0, 1'b1, 3, 0, 64, 0);

    // Saturation in both directions.
    send(max_s, 1'b0, 1, 0, 0, 0);
    send(max_s, 1'b1, 1, 128, 128, 0);
    send(min_s, 1'b0, 1, 0, 0, 0);
    send(min_s, 1'b1, 1, 255, 255, 0);

    // Delay clamping at both ends.
    send(777, 1'b1, 0, 100, 200, 0);
    send(-555, 1'b1, (1 << AW) - 1, 50, 255, 0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << AW) - 1))
                                        : int'($urandom_range(0, SIZE + 5));
      send(($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 4000)) - 2000
                                       : rand_sample(),
           1'(($urandom_range(0, 4) != 0)), dly,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
    end

    // Longest delay across a full write-pointer wrap.
    for (int i = 0; i < SIZE + 5; i++) begin
      send(rand_sample(), 1'b1, SIZE - 1, int'($urandom_range(0, 160)),
           int'($urandom_range(0, 255)), 0);
    end

    // Strobe while busy is dropped and sets the sticky flag.
    send(4321, 1'b1, 2, 64, 64, 1);
    send(-99, 1'b1, 2, 64, 64, 0);
    send(250, 1'b0, 2, 0, 0, 0);

    // Reset mid-sample: no write happens, clear restarts, overrun is cleared.
    send(31337, 1'b1, 4, 32, 32, 2);
    do_clear();
    check_val("overrun_cleared", bus.OVERRUN, 0);
    send(2048, 1'b1, 1, 64, 64, 0);
    send(0, 1'b1, 1, 64, 64, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
